bcd_seg_scan: RTL and testbench

Display-side consumer of the minute countdown's 8-bit BCD value {tens, units} and its one-cycle time_out pulse. It time-multiplexes two common-anode 7-segment digits and decodes BCD to segments. On time_out it runs a finite blink alarm sequence. It sits between the countdown timer and the board's segment/digit pins.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/bcd_to_seg.sv | 29 ++
 rtl/bcd_seg_scan.sv | 144 ++++++++++++++
 tb/tb_bcd_seg_scan.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the BCD 7-segment scan display.
// Holds the active-low segment patterns (bit order gfedcba), the digit-enable
// encodings and the blink FSM state type.
package seg_pkg;

  // Active-low segment patterns, bit0=a ... bit6=g
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Active-low digit enables, bit0=units, bit1=tens
  localparam logic [1:0] DIG_UNITS = 2'b10;
  localparam logic [1:0] DIG_TENS  = 2'b01;
  localparam logic [1:0] DIG_OFF   = 2'b11;

  typedef enum logic {
    IDLE,
    BLINK
  } blink_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd - 4-bit digit; values 10..15 decode to a dash
//   seg - active-low segments, bit0=a ... bit6=g
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed common-anode 7-segment driver with a blink alarm.
// The BCD value is latched into a shadow register at each frame start so a
// frame never mixes old and new digits. A time_out pulse starts (or restarts)
// a finite off/on blink sequence during which alarm is high.
// Optional build macro: LZ_BLANK_EN blanks a leading tens zero.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   bcd_in   - [7:4] tens, [3:0] units, BCD
//   time_out - single-cycle expiry pulse
//   seg      - active-low segments, bit0=a ... bit6=g (registered)
//   dig_sel  - active-low digit enables, bit0=units, bit1=tens (registered)
//   alarm    - high while the blink sequence runs
module bcd_seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_DIV    = 25000000,
  parameter int unsigned BLINK_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_in,
  input  logic       time_out,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       alarm
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned HALF_W  = $clog2(2 * BLINK_CYCLES + 1);

  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HALF_W-1:0]  HALF_LAST = HALF_W'(2 * BLINK_CYCLES - 1);

  logic [SCAN_W-1:0]  scan_cnt_q;
  logic               idx_q;
  logic [7:0]         shadow_q;

  blink_state_e       state_q, state_d;
  logic               phase_on_q, phase_on_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [HALF_W-1:0]  half_cnt_q, half_cnt_d;

  logic [6:0]         seg_d;
  logic [1:0]         dig_sel_d;
  logic [3:0]         nibble;
  logic [6:0]         nibble_seg;

  // Scan counter and frame shadow; runs regardless of the blink FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= 1'b0;
      shadow_q   <= 8'h00;
    end else if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_q <= '0;
      idx_q      <= ~idx_q;
      if (idx_q) begin
        shadow_q <= bcd_in;
      end
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end

  // Blink FSM next state
  always_comb begin
    state_d     = state_q;
    phase_on_d  = phase_on_q;
    blink_cnt_d = blink_cnt_q;
    half_cnt_d  = half_cnt_q;
    if (time_out) begin
      // Start or restart; takes priority over the final wrap
      state_d     = BLINK;
      phase_on_d  = 1'b0;
      blink_cnt_d = '0;
      half_cnt_d  = '0;
    end else if (state_q == BLINK) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
        half_cnt_d  = half_cnt_q + HALF_W'(1);
        if (half_cnt_q == HALF_LAST) begin
          state_d = IDLE;
        end
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_on_q  <= 1'b0;
      blink_cnt_q <= '0;
      half_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_on_q  <= phase_on_d;
      blink_cnt_q <= blink_cnt_d;
      half_cnt_q  <= half_cnt_d;
    end
  end

  assign nibble = idx_q ? shadow_q[7:4] : shadow_q[3:0];

  bcd_to_seg u_bcd_to_seg (
    .bcd (nibble),
    .seg (nibble_seg)
  );

  // Output select; registered below so outputs lag idx/shadow/FSM by one clk
  always_comb begin
    seg_d     = nibble_seg;
    dig_sel_d = idx_q ? DIG_TENS : DIG_UNITS;
    if (state_q == BLINK && !phase_on_q) begin
      seg_d     = SEG_OFF;
      dig_sel_d = DIG_OFF;
    end
`ifdef LZ_BLANK_EN
    else if (idx_q && shadow_q[7:4] == 4'd0) begin
      seg_d     = SEG_OFF;
      dig_sel_d = DIG_OFF;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg     <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      seg     <= seg_d;
      dig_sel <= dig_sel_d;
    end
  end

  assign alarm = (state_q == BLINK);

endmodule

// File: tb/tb_bcd_seg_scan.sv
module tb_bcd_seg_scan;

  localparam int SD   = 4;
  localparam int BD   = 8;
  localparam int BC   = 2;
  localparam int AL   = 2 * BC * BD;
  localparam int MAXK = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bcd_in;
  logic       time_out;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       alarm;

  bcd_seg_scan #(
    .SCAN_DIV     (SD),
    .BLINK_DIV    (BD),
    .BLINK_CYCLES (BC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .time_out (time_out),
    .seg      (seg),
    .dig_sel  (dig_sel),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;
  int k;                       // clock edges since reset release
  logic [7:0] shadow_h[MAXK];  // frame value in effect after edge k
  int         trig_h[MAXK];    // most recent time_out edge at or before k

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] units_seg;
    logic [1:0] tens_dig;
    logic [6:0] tens_seg;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [6:0] ref_dec(input logic [3:0] n);
    logic [6:0] tbl[10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (n > 4'd9) return 7'h3F;
    return tbl[n];
  endfunction

  function automatic bit lz_en();
`ifdef LZ_BLANK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  function automatic bit m_alarm(input int j);
    return trig_h[j] >= 0 && (j - trig_h[j]) < AL;
  endfunction

  // Advance one edge, update the model, compare every output.
  task automatic step();
    int j;
    logic [7:0] sh;
    logic [6:0] eseg;
    logic [1:0] edig;
    @(posedge clk);
    k++;
    if (k >= MAXK) begin
      $display("FAIL model_range: edge %0d exceeds %0d", k, MAXK);
      $fatal(1);
    end
    trig_h[k]   = time_out ? k : trig_h[k-1];
    shadow_h[k] = (k % (2 * SD) == 0) ? bcd_in : shadow_h[k-1];
    #1;
    j  = k - 1;
    sh = shadow_h[j];
    if (m_alarm(j) && ((j - trig_h[j]) / BD) % 2 == 0) begin
      eseg = 7'h7F;
      edig = 2'b11;
    end else if ((j / SD) % 2 == 0) begin
      eseg = ref_dec(sh[3:0]);
      edig = 2'b10;
    end else if (lz_en() && sh[7:4] == 4'd0) begin
      eseg = 7'h7F;
      edig = 2'b11;
    end else begin
      eseg = ref_dec(sh[7:4]);
      edig = 2'b01;
    end
    chk("model_seg", int'(seg), int'(eseg));
    chk("model_dig", int'(dig_sel), int'(edig));
    chk("model_alarm", int'(alarm), int'(m_alarm(k)));
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst         = 1'b0;
    k           = 0;
    shadow_h[0] = 8'h00;
    trig_h[0]   = -1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_seg"}, int'(seg), 'h7F);
    chk({name, "_dig"}, int'(dig_sel), 'h3);
    chk({name, "_alarm"}, int'(alarm), 0);
  endtask

  // Advance to the next frame start, then check the units and tens slots.
  task automatic frame_check(input string name, input logic [6:0] us, input logic [1:0] td,
                             input logic [6:0] ts);
    for (int i = 0; i < 2 * SD; i++) begin
      step();
      if (k % (2 * SD) == 0) break;
    end
    step();
    chk({name, "_units_dig"}, int'(dig_sel), 'h2);
    chk({name, "_units_seg"}, int'(seg), int'(us));
    repeat (SD) step();
    chk({name, "_tens_dig"}, int'(dig_sel), int'(td));
    chk({name, "_tens_seg"}, int'(seg), int'(ts));
  endtask

  // Pulse time_out, optionally again at offset second_at, and measure alarm.
  task automatic alarm_run(input string name, input int second_at, input int exp_len,
                           input int exp_blank);
    int n;
    int blanks;
    time_out = 1'b1;
    step();
    #1 time_out = 1'b0;
    n      = alarm ? 1 : 0;
    blanks = (seg == 7'h7F && dig_sel == 2'b11) ? 1 : 0;
    for (int i = 1; i < 200 && alarm; i++) begin
      time_out = (second_at > 0 && i == second_at);
      step();
      #1 time_out = 1'b0;
      if (alarm) n++;
      if (seg == 7'h7F && dig_sel == 2'b11) blanks++;
    end
    chk({name, "_len"}, n, exp_len);
    if (exp_blank >= 0) chk({name, "_blank"}, blanks, exp_blank);
  endtask

  initial begin
    logic [1:0] zdig;
    logic [6:0] zseg;
    checks   = 0;
    failures = 0;
    k        = 0;
    zdig     = lz_en() ? 2'b11 : 2'b01;
    zseg     = lz_en() ? 7'h7F : 7'h40;
    vecs[0]  = '{8'h47, 7'h78, 2'b01, 7'h19};
    vecs[1]  = '{8'h3C, 7'h3F, 2'b01, 7'h30};
    vecs[2]  = '{8'h05, 7'h12, zdig, zseg};
    vecs[3]  = '{8'h99, 7'h10, 2'b01, 7'h10};
    vecs[4]  = '{8'hF0, 7'h40, 2'b01, 7'h3F};
    vecs[5]  = '{8'h81, 7'h79, 2'b01, 7'h00};

    rst      = 1'b1;
    bcd_in   = 8'h00;
    time_out = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    release_rst();

    // Run a bit with a live value and an alarm, then reset mid-slot
    bcd_in = 8'h93;
    repeat (10) step();
    time_out = 1'b1;
    step();
    #1 time_out = 1'b0;
    repeat (3) step();
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst_held");
    bcd_in = 8'h47;
    release_rst();
    step();
    chk("first_frame_units_dig", int'(dig_sel), 'h2);
    chk("first_frame_units_seg", int'(seg), 'h40);
    repeat (SD) step();
    chk("first_frame_tens_dig", int'(dig_sel), int'(zdig));
    chk("first_frame_tens_seg", int'(seg), int'(zseg));

    // Table-driven digit patterns
    for (int v = 0; v < 6; v++) begin
      bcd_in = vecs[v].bcd;
      frame_check($sformatf("vec%0d", v), vecs[v].units_seg, vecs[v].tens_dig,
                  vecs[v].tens_seg);
    end

    // No tearing: change value during the tens slot
    bcd_in = 8'h47;
    frame_check("tear_pre", 7'h78, 2'b01, 7'h19);
    bcd_in = 8'h25;
    step();
    chk("tear_hold_seg", int'(seg), 'h19);
    chk("tear_hold_dig", int'(dig_sel), 'h1);
    frame_check("tear_post", 7'h12, 2'b01, 7'h24);

    // Alarm sequences
    alarm_run("alarm_single", 0, AL, AL / 2);
    repeat (5) step();
    alarm_run("alarm_restart", 20, 20 + AL, -1);
    repeat (3) step();
    alarm_run("alarm_final_wrap", AL, 2 * AL, -1);
    repeat (3) step();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) bcd_in = 8'($urandom);
      time_out = ($urandom_range(0, 59) == 0);
      step();
      #1 time_out = 1'b0;
    end

    #2 rst = 1'b1;
    #1 check_reset_outputs("final_rst");
    release_rst();
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
